turbo_iter_ctrl: RTL and testbench

//  Iteration scheduler for the shared Siso decoder core in the turbo decoder.

---
 rtl/turbo_pkg.sv | 19 +
 rtl/turbo_iter_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_turbo_iter_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo decoder control path: FSM states and default geometry.
package turbo_pkg;

  localparam int LLR_W         = 7;
  localparam int FRAME_LEN_DEF = 16;
  localparam int IDX_W_DEF     = 4;
  localparam int ITER_W_DEF    = 4;
  localparam int TIMEOUT_DEF   = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/turbo_iter_ctrl.sv
// Half-iteration scheduler for the shared Siso core: sequences clear/feed/drain per half,
// counts extrinsic write-backs, and tracks iterations, completion and errors.
module turbo_iter_ctrl
  import turbo_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int ITER_W    = ITER_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ITER_W-1:0] iter_num_i,
  input  logic              siso_valid_i,
  output logic              siso_clear_o,
  output logic              siso_read_en_o,
  output logic              half_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  wr_idx_o,
  output logic [ITER_W-1:0] iter_o,
  output logic              final_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int WB_W  = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [WB_W-1:0]  WB_FULL  = WB_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ITER_W-1:0]   target_r;
  logic [ITER_W-1:0]   iter_r;
  logic                half_r;
  logic [IDX_W-1:0]    rd_idx_r;
  logic [WB_W-1:0]     wb_cnt_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                err_r;

  logic                in_wb_s;
  logic                wb_full_s;
  logic                accept_s;
  logic                surplus_s;
  logic                last_iter_s;
  logic                last_half_s;
  logic                timeout_s;

  assign in_wb_s     = (state_r == ST_FEED) || (state_r == ST_DRAIN);
  assign wb_full_s   = (wb_cnt_r == WB_FULL);
  assign accept_s    = siso_valid_i & in_wb_s & ~wb_full_s;
  assign surplus_s   = siso_valid_i & in_wb_s & wb_full_s;
  assign last_iter_s = (iter_r == (target_r - ITER_W'(1)));
  assign last_half_s = half_r & last_iter_s;
  // Idle cycles are only counted once the read phase is over.
  assign timeout_s   = (state_r == ST_DRAIN) & ~wb_full_s & ~siso_valid_i &
                       (tmo_cnt_r == TMO_LAST);

  // Target iteration count with the zero request mapped to a single iteration.
  function automatic logic [ITER_W-1:0] clamp_target(input logic [ITER_W-1:0] req);
    logic [ITER_W-1:0] res;
    if (req == '0) begin
      res = ITER_W'(1);
    end else begin
      res = req;
    end
    return res;
  endfunction

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection and state-decoded strobes; abort overrides everything.
  always_comb begin
    state_nxt_s    = state_r;
    siso_clear_o   = 1'b0;
    siso_read_en_o = 1'b0;
    busy_o         = (state_r != ST_IDLE);
    done_o         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        siso_clear_o = 1'b1;
        state_nxt_s  = ST_FEED;
      end
      ST_FEED: begin
        siso_read_en_o = 1'b1;
        if (rd_idx_r == IDX_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (wb_full_s) begin
          state_nxt_s = ST_NEXT;
        end else if (timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_NEXT: begin
        if (last_half_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (abort_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Iteration, half and read-index sequencing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      target_r <= '0;
      iter_r   <= '0;
      half_r   <= 1'b0;
      rd_idx_r <= '0;
    end else if (!abort_i) begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            target_r <= clamp_target(iter_num_i);
            iter_r   <= '0;
            half_r   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          rd_idx_r <= '0;
        end
        ST_FEED: begin
          if (rd_idx_r != IDX_LAST) begin
            rd_idx_r <= rd_idx_r + IDX_W'(1);
          end
        end
        ST_NEXT: begin
          if (!last_half_s) begin
            if (half_r) begin
              iter_r <= iter_r + ITER_W'(1);
            end
            half_r <= ~half_r;
          end
        end
        default: begin
          rd_idx_r <= rd_idx_r;
        end
      endcase
    end
  end

  // Write-back counter, idle timeout and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_cnt_r  <= '0;
      tmo_cnt_r <= '0;
      err_r     <= 1'b0;
    end else if (!abort_i) begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            err_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          wb_cnt_r  <= '0;
          tmo_cnt_r <= '0;
        end
        ST_FEED, ST_DRAIN: begin
          if (accept_s) begin
            wb_cnt_r <= wb_cnt_r + WB_W'(1);
          end
          if (surplus_s || timeout_s) begin
            err_r <= 1'b1;
          end
          if (state_r == ST_DRAIN) begin
            if (siso_valid_i) begin
              tmo_cnt_r <= '0;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
          end
        end
        default: begin
          wb_cnt_r <= wb_cnt_r;
        end
      endcase
    end
  end

  assign half_o   = half_r;
  assign rd_idx_o = rd_idx_r;
  assign wr_en_o  = accept_s;
  assign wr_idx_o = wb_cnt_r[IDX_W-1:0];
  assign iter_o   = iter_r;
  assign err_o    = err_r;
  assign final_o  = busy_o & half_r & last_iter_s;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Randomised-latency Siso model driving turbo_iter_ctrl; expectations come from a closed-form
// per-cycle schedule of halves (clear, feed, drain, next) and a per-half write-back count.
module tb_turbo_iter_ctrl;

  localparam int FL  = 16;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] iter_num;
  logic       valid;
  logic       siso_clear_o, siso_read_en_o, half_o, wr_en_o, final_o, busy_o, done_o, err_o;
  logic [3:0] rd_idx_o, wr_idx_o, iter_o;

  int n_chk  = 0;
  int n_fail = 0;

  turbo_iter_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .iter_num_i    (iter_num),
    .siso_valid_i  (valid),
    .siso_clear_o  (siso_clear_o),
    .siso_read_en_o(siso_read_en_o),
    .half_o        (half_o),
    .rd_idx_o      (rd_idx_o),
    .wr_en_o       (wr_en_o),
    .wr_idx_o      (wr_idx_o),
    .iter_o        (iter_o),
    .final_o       (final_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".clear"},  32'(siso_clear_o),   32'd0);
    chk({tag, ".read"},   32'(siso_read_en_o), 32'd0);
    chk({tag, ".half"},   32'(half_o),         32'd0);
    chk({tag, ".rd_idx"}, 32'(rd_idx_o),       32'd0);
    chk({tag, ".wr_en"},  32'(wr_en_o),        32'd0);
    chk({tag, ".wr_idx"}, 32'(wr_idx_o),       32'd0);
    chk({tag, ".iter"},   32'(iter_o),         32'd0);
    chk({tag, ".final"},  32'(final_o),        32'd0);
    chk({tag, ".busy"},   32'(busy_o),         32'd0);
    chk({tag, ".done"},   32'(done_o),         32'd0);
    chk({tag, ".err"},    32'(err_o),          32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; valid = 1'b0;
      #1;
      chk("idle.busy", 32'(busy_o), 32'd0);
      chk("idle.done", 32'(done_o), 32'd0);
    end
  endtask

  // mode: 0 normal, 1 Siso stops after 10 valids (timeout), 2 surplus valid in half param,
  //       3 abort at cycle param, 4 start pulse at cycle param, 5 start at 10 + reset at param
  task automatic run_frame(input int inum, input int lat, input int mode, input int param);
    int  t_it, n_half, per, done_c, last_c, h, o, vcount, nsent, exp_half, exp_iter;
    bit  active, isdone, win, v, acc, exp_err, exp_read;
    bit  rh [512];
    t_it    = (inum == 0) ? 1 : inum;
    n_half  = 2 * t_it;
    per     = FL + 3 + lat;
    done_c  = (mode == 1) ? (FL + 2 + TMO) : (n_half * per + 1);
    last_c  = (mode == 3) ? param : done_c;
    exp_err = 1'b0;
    vcount  = 0;
    nsent   = 0;
    iter_num = 4'(inum);
    for (int c = 0; c <= last_c + 2; c++) begin
      @(negedge clk);
      rh[c]  = siso_read_en_o;
      active = (c >= 1) && (c < done_c) && !(mode == 3 && c > param);
      isdone = (c == done_c) && (mode != 3);
      if (mode == 1) begin
        h = 0; o = c - 1;
      end else begin
        h = (c - 1) / per; o = (c - 1) % per;
      end
      if (active && o == 0) begin
        vcount = 0; nsent = 0;
      end
      win = active && (o >= 1) && (mode == 1 || o <= per - 2);
      v = (c >= lat) ? rh[c - lat] : 1'b0;
      if (mode == 1 && nsent >= 10) v = 1'b0;
      if (mode == 3 && c == param) v = 1'b0;
      if (c == 1) v = 1'b1;
      if (mode == 2 && active && h == param && o == per - 2) v = 1'b1;
      start = (c == 0) || (mode == 4 && c == param) || (mode == 5 && c == 10);
      abort = (mode == 3 && c == param);
      valid = v;
      #1;
      exp_read = active && (o >= 1) && (o <= FL);
      chk("busy",    32'(busy_o),         32'(active || isdone));
      chk("done",    32'(done_o),         32'(isdone));
      chk("clear",   32'(siso_clear_o),   32'(active && o == 0));
      chk("read_en", 32'(siso_read_en_o), 32'(exp_read));
      if (exp_read) chk("rd_idx", 32'(rd_idx_o), 32'(o - 1));
      if (active || isdone) begin
        exp_half = isdone ? ((mode == 1) ? 0 : 1) : (h % 2);
        exp_iter = isdone ? ((mode == 1) ? 0 : t_it - 1) : (h / 2);
        chk("half",  32'(half_o),  32'(exp_half));
        chk("iter",  32'(iter_o),  32'(exp_iter));
        chk("final", 32'(final_o), 32'(exp_half == 1 && exp_iter == t_it - 1));
      end else begin
        chk("final", 32'(final_o), 32'd0);
      end
      acc = v && win && (vcount < FL);
      chk("wr_en", 32'(wr_en_o), 32'(acc));
      if (acc) begin
        chk("wr_idx", 32'(wr_idx_o), 32'(vcount));
        vcount++;
      end
      if (v && win) nsent++;
      if (mode == 1 && c == done_c) exp_err = 1'b1;
      if (c >= 1) chk("err", 32'(err_o), 32'(exp_err));
      if (v && win && !acc) exp_err = 1'b1;
      if (mode == 5 && c == param) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        start = 1'b0; valid = 1'b0;
        @(negedge clk);
        #1 check_all_zero("rst_hold");
        rst_n = 1'b1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; iter_num = 4'd0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    run_frame(1, 3, 0, 0);
    run_frame(1, 0, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(3, 2, 0, 0);
    run_frame(1, 3, 1, 0);
    run_frame(2, 0, 2, 1);
    run_frame(2, 1, 3, 47);
    run_frame(2, 1, 0, 0);

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_start.busy",  32'(busy_o),       32'd0);
    chk("abort_start.clear", 32'(siso_clear_o), 32'd0);
    idle_cycles(2);

    run_frame(3, 2, 4, 30);
    run_frame(2, 5, 5, 20);
    idle_cycles(4);

    for (int k = 0; k < 6; k++) begin
      run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
